// File: rtl/screen_scanner_if.sv
// Bus between the screen scanner, the screen RAM read port and the display back end.
// The master side is the scanner. The slave side is the RAM plus the display.
interface screen_scanner_if;
    logic [12:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        pix;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output mem_addr, pix, de, hsync, vsync, frame_start,
        input  mem_rdata
    );
    modport slave (
        input  mem_addr, pix, de, hsync, vsync, frame_start,
        output mem_rdata
    );
endinterface

// File: rtl/screen_scanner.sv
// Raster scanner for the 512x256 Hack frame buffer: fetches screen words and emits pixels and sync.
// Define SCREEN_SCANNER_INVERT_EN to invert active pixels (dark-on-light).
module screen_scanner #(
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    screen_scanner_if.master      bus
);
    localparam int H_ACTIVE = 512;
    localparam int V_ACTIVE = 256;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL  = V_ACTIVE + V_BLANK;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_END  = VW'(V_ACTIVE);

`ifdef SCREEN_SCANNER_INVERT_EN
    localparam logic INVERT = 1'b1;
`else
    localparam logic INVERT = 1'b0;
`endif

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt, vcnt_inc;
    logic [14:0]   shreg, shreg_nxt;
    logic [12:0]   addr_nxt;
    logic [4:0]    word_idx;
    logic          h_act, v_act, active, pix_nxt;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        h_act    = hcnt < H_END;
        v_act    = vcnt < V_END;
        active   = h_act && v_act;
        word_idx = hcnt[8:4];

        vcnt_inc = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        vcnt_nxt = (hcnt == H_LAST) ? vcnt_inc : vcnt;

        // First pixel of a group comes straight from the RAM; the rest drain the shift register.
        pix_nxt   = 1'b0;
        shreg_nxt = shreg;
        if (active) begin
            if (hcnt[3:0] == 4'd0) begin
                pix_nxt   = bus.mem_rdata[0] ^ INVERT;
                shreg_nxt = bus.mem_rdata[15:1];
            end else begin
                pix_nxt   = shreg[0] ^ INVERT;
                shreg_nxt = {1'b0, shreg[14:1]};
            end
        end

        // Prefetch mid-group so slow sync-read RAM still has a full cycle before the load.
        addr_nxt = bus.mem_addr;
        if (active && hcnt[3:0] == 4'd8 && word_idx != 5'd31)
            addr_nxt = {vcnt[7:0], word_idx + 5'd1};
        else if (hcnt == H_END)
            addr_nxt = (vcnt_inc < V_END) ? {vcnt_inc[7:0], 5'd0} : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt            <= '0;
            vcnt            <= V_END;
            shreg           <= '0;
            bus.mem_addr    <= '0;
            bus.pix         <= 1'b0;
            bus.de          <= 1'b0;
            bus.hsync       <= 1'b0;
            bus.vsync       <= 1'b0;
            bus.frame_start <= 1'b0;
        end else if (en) begin
            hcnt            <= hcnt_nxt;
            vcnt            <= vcnt_nxt;
            shreg           <= shreg_nxt;
            bus.mem_addr    <= addr_nxt;
            bus.pix         <= pix_nxt;
            bus.de          <= active;
            bus.hsync       <= !h_act;
            bus.vsync       <= !v_act;
            bus.frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end
endmodule

// File: doc/screen_scanner.md
Name: screen_scanner

Overview:
- Read-side companion to the 8K-word screen RAM that the CPU writes.
- Walks the 512x256 Hack frame buffer (32 words per row, 256 rows) in raster order.
- Fetches one 16-bit word per 16 pixels and serialises it to a 1-bit pixel stream.
- Generates blanking, sync and frame markers for a display back end.

Parameters:
- H_BLANK, 16: horizontal blanking cycles per line. Must be at least 2.
- V_BLANK, 4: blank lines per frame. Must be at least 1.

Ports:
- clk  input  1  system clock. All state updates on the posedge.
- reset  input  1  synchronous, active-low reset. The block is reset on any posedge where reset=0.
- en  input  1  scan enable. When 0, all state and outputs hold.
- mem_addr  output  13  word address into the screen RAM. Registered.
- mem_rdata  input  16  word returned for mem_addr.
- pix  output  1  pixel value. Registered.
- de  output  1  active-video flag.
- hsync  output  1  horizontal blanking flag.
- vsync  output  1  vertical blanking flag.
- frame_start  output  1  one-cycle pulse on pixel (0,0).

Behaviour:
- Constants:
  - H_ACTIVE=512, V_ACTIVE=256.
  - H_TOTAL=H_ACTIVE+H_BLANK (default 528).
  - V_TOTAL=V_ACTIVE+V_BLANK (default 260).
- Position counters hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1) are internal.
  - hcnt wraps to 0 and vcnt increments.
  - vcnt wraps to 0 after V_TOTAL-1.
- Reset (reset=0 at posedge, overrides en):
  - hcnt=0, vcnt=V_ACTIVE. The scan starts at the top of vertical blank.
  - mem_addr=0, shift register=0.
  - pix=de=hsync=vsync=frame_start=0.
  - Reset mid-line or mid-frame aborts immediately. No partial state survives.
- Normal edge (reset=1, en=1):
  - Outputs are registered from the current (hcnt,vcnt), then the counters advance.
  - Outputs therefore lag the counters by exactly 1 cycle. All outputs are mutually aligned.
- Stall edge (reset=1, en=0): counters, mem_addr, shift register and all outputs hold.
- Output decode for position (h,v):
  - de = (h<512 && v<256).
  - hsync = (h>=512).
  - vsync = (v>=256).
  - frame_start = (h==0 && v==0).
  - pix = de ? word[h mod 16] : 0, where word = M[v*32 + h/16].
  - Bit 0 of each word is the leftmost pixel.
- Fetch timing (requires mem_rdata valid no later than 1 cycle after mem_addr changes; satisfies both async-read and 1-cycle sync-read RAM):
  - Load: at the edge processing position h=16w (w=0..31, v active), mem_rdata is sampled. Bit 0 drives pix; bits 15:1 load the shift register.
  - Shift: edges at the remaining 15 positions of the group drive pix from the shift register LSB and shift right.
  - Advance: at the edge processing h=16w+8 (w<31, v active), mem_addr becomes v*32+w+1.
  - Next line: at the edge processing h=512 of any line v, mem_addr becomes ((v+1) mod V_TOTAL, clamped to row 0 if not active)*32.
  - During vertical blank, mem_addr therefore sits at 0, ready for row 0.
- mem_addr never changes between posedges and never exceeds 8191.
- Frame length: H_TOTAL*V_TOTAL enabled cycles (default 137280).

Optional Feature:
- Macro: SCREEN_SCANNER_INVERT_EN.
- Defined: pix = de ? ~word[h mod 16] : 0. Memory 1 reads as dark-on-light; blanking is still 0.
- Undefined: pix as above, uninverted.
- No other behaviour, timing or port differences.

Test Plan:
- Reset, then en=1 with all memory 0:
  - de=0 for the first 2112 enabled edges.
  - Edge 2113 gives de=1, frame_start=1, pix=0.
  - frame_start recurs every 137280 edges.
- M[0]=16'h0001, M[31]=16'h8000, rest 0:
  - pix=1 only at (x=0,y=0) and (x=511,y=0) in each frame.
  - mem_addr reads 1 at the edge after pixel 8.
- M[8191]=16'hAAAA: row 255, x=496..511 gives pix 0,1,0,1,...,1. The other rows of that column group give pix=0.
- Drop en to 0 for 10 cycles while the output shows x=100,y=3:
  - All outputs and mem_addr hold for 10 cycles.
  - The next enabled edge outputs x=101,y=3 with the correct bit.
- Assert reset=0 for one edge while the output shows x=300,y=10:
  - All outputs become 0 and mem_addr becomes 0.
  - frame_start next appears 2113 enabled edges after release.
- Per line: hsync=1 for exactly 16 consecutive cycles, and de=1 for exactly 512 cycles.
- Per frame: vsync=1 for exactly 2112 cycles.
- With SCREEN_SCANNER_INVERT_EN defined and memory 0: pix=1 on all 131072 active pixels and 0 in blanking.
